// File: rtl/dict_wr_sched.sv
// Dictionary write scheduler: pairs miss words from a two-lane stream into row writes.
// Optional HOLD timeout (single-word write of a lone word) enabled by DICT_WR_SCHED_TIMEOUT_EN.
module dict_wr_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE       = 8,
  parameter int unsigned TIMEOUT    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_data_a,
  input  logic                      i_ins_a,
  input  logic [DATA_WIDTH-1:0]     i_data_b,
  input  logic                      i_ins_b,
  output logic                      o_ready,
  input  logic                      i_dict_hold,
  input  logic                      i_flush,
  output logic                      o_flush_done,
  output logic                      o_wr,
  output logic                      o_wr2,
  output logic [DATA_WIDTH-1:0]     o_w_data,
  output logic [DATA_WIDTH-1:0]     o_w_data2,
  output logic [$clog2(SIZE):0]     o_fill,
  output logic                      o_dict_full
);

  localparam int unsigned FILL_W  = $clog2(SIZE) + 1;
  localparam int unsigned TIMER_W = 8;

  // Elaboration-time parameter range checks
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dict_wr_sched: TIMEOUT must be in 1..255");
  end
  if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
    $error("dict_wr_sched: SIZE must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   h_q, h_d;
  logic [DATA_WIDTH-1:0]   w_data_d, w_data2_d;
  logic                    wr_d, wr2_d, flush_done_d, dict_full_d;
  logic [FILL_W-1:0]       fill_d;
  logic                    accept;
  logic [1:0]              n_cand;
  logic [DATA_WIDTH-1:0]   cand0;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
  logic [TIMER_W-1:0]      timer_q, timer_d;
`endif

  assign o_ready = ~i_reset & ~i_dict_hold & ~i_flush & (state_q != ST_FLUSH);
  assign accept  = i_valid & o_ready;
  assign n_cand  = 2'(i_ins_a) + 2'(i_ins_b);
  // Oldest candidate of the beat: lane A if it is a miss, otherwise lane B
  assign cand0   = i_ins_a ? i_data_a : i_data_b;

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    wr_d         = 1'b0;
    wr2_d        = 1'b0;
    w_data_d     = o_w_data;
    w_data2_d    = o_w_data2;
    flush_done_d = 1'b0;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
    timer_d      = timer_q;
`endif

    if (!i_dict_hold) begin
      case (state_q)
        ST_IDLE: begin
          if (i_flush) begin
            flush_done_d = 1'b1;
          end else if (accept && n_cand == 2'd2) begin
            wr_d      = 1'b1;
            wr2_d     = 1'b1;
            w_data_d  = i_data_a;
            w_data2_d = i_data_b;
          end else if (accept && n_cand == 2'd1) begin
            h_d     = cand0;
            state_d = ST_HOLD;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
            timer_d = '0;
`endif
          end
        end

        ST_HOLD: begin
          if (i_flush) begin
            wr_d     = 1'b1;
            w_data_d = h_q;
            state_d  = ST_FLUSH;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
            timer_d  = '0;
`endif
          end else if (accept && n_cand == 2'd2) begin
            wr_d      = 1'b1;
            wr2_d     = 1'b1;
            w_data_d  = h_q;
            w_data2_d = i_data_a;
            h_d       = i_data_b;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
            timer_d   = '0;
`endif
          end else if (accept && n_cand == 2'd1) begin
            wr_d      = 1'b1;
            wr2_d     = 1'b1;
            w_data_d  = h_q;
            w_data2_d = cand0;
            state_d   = ST_IDLE;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
            timer_d   = '0;
`endif
          end else begin
`ifdef DICT_WR_SCHED_TIMEOUT_EN
            // This idle cycle brings the count up to TIMEOUT: flush H alone
            if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
              wr_d     = 1'b1;
              w_data_d = h_q;
              state_d  = ST_IDLE;
              timer_d  = '0;
            end else begin
              timer_d  = timer_q + TIMER_W'(1);
            end
`endif
          end
        end

        ST_FLUSH: begin
          flush_done_d = 1'b1;
          state_d      = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end

    fill_d      = (wr_d && (o_fill != FILL_W'(SIZE))) ? o_fill + FILL_W'(1) : o_fill;
    dict_full_d = (fill_d == FILL_W'(SIZE));
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      o_wr         <= 1'b0;
      o_wr2        <= 1'b0;
      o_w_data     <= '0;
      o_w_data2    <= '0;
      o_flush_done <= 1'b0;
      o_fill       <= '0;
      o_dict_full  <= 1'b0;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      o_wr         <= wr_d;
      o_wr2        <= wr2_d;
      o_w_data     <= w_data_d;
      o_w_data2    <= w_data2_d;
      o_flush_done <= flush_done_d;
      o_fill       <= fill_d;
      o_dict_full  <= dict_full_d;
`ifdef DICT_WR_SCHED_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_dict_wr_sched.sv
// Bench for dict_wr_sched: directed scenarios plus random traffic against a queue-based model.
module tb_dict_wr_sched;

  localparam int unsigned DW      = 32;
  localparam int unsigned SIZE    = 8;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned FW      = $clog2(SIZE) + 1;

  logic          i_clk, i_reset, i_valid, i_ins_a, i_ins_b, i_dict_hold, i_flush;
  logic [DW-1:0] i_data_a, i_data_b;
  logic          o_ready, o_flush_done, o_wr, o_wr2, o_dict_full;
  logic [DW-1:0] o_w_data, o_w_data2;
  logic [FW-1:0] o_fill;

  dict_wr_sched #(.DATA_WIDTH(DW), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_data_a(i_data_a), .i_ins_a(i_ins_a), .i_data_b(i_data_b), .i_ins_b(i_ins_b),
    .o_ready(o_ready), .i_dict_hold(i_dict_hold), .i_flush(i_flush),
    .o_flush_done(o_flush_done), .o_wr(o_wr), .o_wr2(o_wr2),
    .o_w_data(o_w_data), .o_w_data2(o_w_data2), .o_fill(o_fill), .o_dict_full(o_dict_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending words waiting for a partner, plus flush/tick bookkeeping
  logic [DW-1:0] pend[$];
  bit            m_flushing = 1'b0;
  int            m_tick = 0;
  bit            m_wr = 1'b0, m_wr2 = 1'b0, m_done = 1'b0;
  logic [DW-1:0] m_d = '0, m_d2 = '0;
  int            m_fill = 0;

  function automatic void m_write(input bit pair, input logic [DW-1:0] a, input logic [DW-1:0] b);
    m_wr = 1'b1;
    m_d  = a;
    if (pair) begin
      m_wr2 = 1'b1;
      m_d2  = b;
    end
    if (m_fill < SIZE) m_fill++;
  endfunction

  function automatic void model_step(input bit acc);
    logic [DW-1:0] x, y;
    m_wr = 1'b0; m_wr2 = 1'b0; m_done = 1'b0;
    if (i_reset) begin
      pend.delete(); m_flushing = 1'b0; m_tick = 0;
      m_d = '0; m_d2 = '0; m_fill = 0;
    end else if (i_dict_hold) begin
      // everything frozen
    end else if (m_flushing) begin
      m_done = 1'b1;
      m_flushing = 1'b0;
    end else if (i_flush) begin
      if (pend.size() == 0) m_done = 1'b1;
      else begin
        x = pend.pop_front();
        m_write(1'b0, x, '0);
        m_flushing = 1'b1;
        m_tick = 0;
      end
    end else if (acc && (i_ins_a || i_ins_b)) begin
      if (i_ins_a) pend.push_back(i_data_a);
      if (i_ins_b) pend.push_back(i_data_b);
      if (pend.size() >= 2) begin
        x = pend.pop_front();
        y = pend.pop_front();
        m_write(1'b1, x, y);
      end
      m_tick = 0;
    end else if (pend.size() == 1) begin
`ifdef DICT_WR_SCHED_TIMEOUT_EN
      m_tick++;
      if (m_tick == TIMEOUT) begin
        x = pend.pop_front();
        m_write(1'b0, x, '0);
        m_tick = 0;
      end
`endif
    end
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] a, input bit ia,
                       input logic [DW-1:0] b, input bit ib,
                       input bit hold, input bit fl, input bit rst);
    i_valid = v; i_data_a = a; i_ins_a = ia; i_data_b = b; i_ins_b = ib;
    i_dict_hold = hold; i_flush = fl; i_reset = rst;
  endtask

  // One clock: check o_ready before the edge, outputs just after it
  task automatic cycle();
    bit rdy, acc;
    #1;
    rdy = !i_reset && !i_dict_hold && !i_flush && !m_flushing;
    chk("ready", 64'(o_ready), 64'(rdy));
    acc = i_valid && rdy;
    @(posedge i_clk);
    model_step(acc);
    #1;
    chk("wr",     64'(o_wr),         64'(m_wr));
    chk("wr2",    64'(o_wr2),        64'(m_wr2));
    chk("done",   64'(o_flush_done), 64'(m_done));
    chk("wdata",  64'(o_w_data),     64'(m_d));
    chk("wdata2", 64'(o_w_data2),    64'(m_d2));
    chk("fill",   64'(o_fill),       64'(m_fill));
    chk("full",   64'(o_dict_full),  64'(m_fill == SIZE));
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    drive(0, '0, 0, '0, 0, 0, 0, 1); cycle();
    drive(0, '0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic beat(input logic [DW-1:0] a, input bit ia, input logic [DW-1:0] b, input bit ib);
    drive(1, a, ia, b, ib, 0, 0, 0); cycle();
  endtask

  task automatic idle();
    drive(0, '0, 0, '0, 0, 0, 0, 0); cycle();
  endtask

  initial begin
    drive(0, '0, 0, '0, 0, 0, 0, 1);
    @(negedge i_clk);
    do_reset();
    chk("rst_fill", 64'(o_fill), 64'd0);
    chk("rst_wr",   64'(o_wr),   64'd0);

    // Pair write from IDLE
    beat(32'h11111111, 1, 32'h22222222, 1);
    chk("s_pair_wr",  64'({o_wr, o_wr2}), 64'd3);
    chk("s_pair_d",   64'(o_w_data),  64'h11111111);
    chk("s_pair_d2",  64'(o_w_data2), 64'h22222222);
    chk("s_pair_fill", 64'(o_fill), 64'd1);

    // Hold then pair, then H=0xCC proven by pairing with the next candidate
    beat(32'hAA, 1, 32'h33, 0);
    chk("s_hold_nowr", 64'(o_wr), 64'd0);
    beat(32'hBB, 1, 32'hCC, 1);
    chk("s_hp_d",  64'(o_w_data),  64'hAA);
    chk("s_hp_d2", 64'(o_w_data2), 64'hBB);
    beat(32'h44, 0, 32'hDD, 1);
    chk("s_hp2_d",  64'(o_w_data),  64'hCC);
    chk("s_hp2_d2", 64'(o_w_data2), 64'hDD);

    // Lone word waiting for TIMEOUT idle cycles
    do_reset();
    beat(32'h55, 1, 32'h0, 0);
    repeat (TIMEOUT) idle();
`ifdef DICT_WR_SCHED_TIMEOUT_EN
    chk("s_to_wr",  64'({o_wr, o_wr2}), 64'd2);
    chk("s_to_d",   64'(o_w_data), 64'h55);
`else
    chk("s_to_nowr", 64'(o_wr), 64'd0);
`endif

    // Flush in HOLD, then flush in IDLE
    do_reset();
    beat(32'h77, 1, 32'h0, 0);
    drive(1, 32'h1, 1, 32'h2, 1, 0, 1, 0); cycle();
    chk("s_fl_wr", 64'({o_wr, o_wr2}), 64'd2);
    chk("s_fl_d",  64'(o_w_data), 64'h77);
    chk("s_fl_nodone", 64'(o_flush_done), 64'd0);
    idle();
    chk("s_fl_done", 64'(o_flush_done), 64'd1);
    idle();
    chk("s_fl_done0", 64'(o_flush_done), 64'd0);
    drive(0, '0, 0, '0, 0, 0, 1, 0); cycle();
    chk("s_fli_done", 64'(o_flush_done), 64'd1);
    chk("s_fli_nowr", 64'(o_wr), 64'd0);

    // Dictionary hold freezes everything; then saturate fill
    do_reset();
    drive(1, 32'h1, 1, 32'h2, 1, 1, 0, 0); cycle();
    drive(1, 32'h1, 1, 32'h2, 1, 1, 1, 0); cycle();
    chk("s_dh_nowr", 64'(o_wr), 64'd0);
    for (int i = 0; i < 10; i++) beat(DW'(i), 1, DW'(i + 100), 1);
    chk("s_sat_fill", 64'(o_fill), 64'(SIZE));
    chk("s_sat_full", 64'(o_dict_full), 64'd1);

    // Reset while holding drops H
    do_reset();
    beat(32'h99, 1, 32'h0, 0);
    do_reset();
    drive(0, '0, 0, '0, 0, 0, 1, 0); cycle();
    chk("s_rh_nowr", 64'(o_wr), 64'd0);
    chk("s_rh_done", 64'(o_flush_done), 64'd1);
    idle();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1,
            DW'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) drive(0, '0, 0, '0, 0, 0, 0, 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
